bus_dest_bank: RTL and testbench
================================

// Module: bus_dest_bank
// PURPOSE
//   Destination (load) side of the datapath bus: latches BusMuxOut into the GPRs
//   R0-R15 and into HI, LO, PC, MDR, IR and the 64-bit Z register on the *in strobes.
//   Holds the select/encode logic that turns IR register fields into the GPR
//   load and drive one-hots.
//   Returns every register value and the drive one-hot to the bus multiplexer.
// PARAMETERS
//   DW      32   datapath width
//   NGPR    16   general-purpose register count (index width = 4)
// PORTS
//   clock          in   1        rising-edge clock
//   clear          in   1        synchronous active-high reset
//   BusMuxOut      in   DW       bus value to be loaded
//   Gra/Grb/Grc    in   1 each   select IR[26:23] / IR[22:19] / IR[18:15] as GPR index
//   Rin            in   1        load bus into selected GPR
//   Rout           in   1        drive selected GPR onto bus
//   BAout          in   1        base-address drive; R0 reads as 0 on the bus
//   HIin/LOin      in   1 each   load HI / LO from bus
//   PCin/IncPC     in   1 each   load PC from bus / PC <= PC+1
//   MDRin/Read     in   1 each   load MDR; Read=1 selects Mdatain, else bus
//   Mdatain        in   DW       memory read data
//   IRin           in   1        load IR from bus
//   Zin            in   1        load Z from ALU result C
//   C              in   2*DW     ALU result {high,low}
//   GprOut         out  NGPR*DW  R15..R0, flattened, Rk at [k*DW +: DW]
//   HI/LO/PC/MDR/IR out DW each  register contents
//   ZHigh/ZLow     out  DW each  Z[63:32] / Z[31:0]
//   GprRout        out  NGPR     one-hot GPR drive vector to bus mux
//   CSignExtended  out  DW       IR[18:0] sign-extended from bit 18
//   LoadConflict   out  1        sticky: illegal load combination seen
// BEHAVIOUR
//   - clear=1 at a rising edge clears all registers, Z and LoadConflict to 0.
//     clear overrides every strobe in that cycle.
//   - Select: idx = Gra?IR[26:23] : Grb?IR[22:19] : Grc?IR[18:15] : 0.
//     Priority is Gra > Grb > Grc. No G* asserted selects no register.
//   - Decode: dec = one-hot(idx) when any G* is asserted, else 0.
//     GprLoad = dec & {NGPR{Rin}}.
//     GprRout = dec & {NGPR{Rout|BAout}} (combinational, zero latency).
//   - R0: on the bus, R0 returns 0 when BAout & dec[0]. Inside the bank R0 still
//     stores its real value. GprOut[0 +: DW] = (BAout & dec[0]) ? 0 : R0.
//   - Load latency: 1 cycle. A strobe high at edge N makes the register hold
//     BusMuxOut (or the chosen source) after edge N. Otherwise registers hold.
//   - PC: PCin has priority over IncPC. IncPC alone gives PC <= PC+1, mod 2^DW
//     (32'hFFFFFFFF -> 0).
//   - MDR source is Mdatain when Read=1, else BusMuxOut; it loads only when MDRin=1.
//   - Z <= C on Zin.
//   - Several strobes in one cycle are all honoured; each target loads independently.
//   - LoadConflict sets on an edge where more than one of Gra/Grb/Grc is high while
//     Rin or Rout is high. The load still uses the priority index. The flag stays set
//     until clear.
//   - CSignExtended is combinational from the IR register output, so it follows IR
//     one cycle after IRin.
// STRUCTURE
//   - Shared package (datapath_pkg): DW and NGPR; IR field positions RA_MSB=26,
//     RB_MSB=22, RC_MSB=18, IMM_W=19; reset value 32'h0.
//   - One sub-module: select_encode. Inputs IR, Gra/Grb/Grc, Rin/Rout/BAout. Outputs
//     GprLoad, GprRout, CSignExtended and the conflict pulse. It is purely combinational.
//   - The register storage stays in this module as one generate loop over NGPR plus
//     the named special registers.
// TESTING
//   1 Reset: load arbitrary values, assert clear together with Rin and PCin ->
//     all outputs 0 next cycle, LoadConflict=0.
//   2 GPR load/drive: IR=32'h0118_0000 (ra=2, rb=3). Gra,Rin with bus=32'hDEADBEEF ->
//     R2=DEADBEEF. Grb,Rout -> GprRout=16'h0008.
//   3 BAout on R0: R0 holds 32'h1234, IR ra=0, Gra,BAout -> GprOut R0 slice=0,
//     GprRout=16'h0001. Gra,Rout -> slice=32'h1234.
//   4 PC: PC=32'hFFFFFFFF, IncPC -> 0. Then PCin+IncPC with bus=32'h10 -> PC=32'h10.
//   5 MDR/Z/sign-extend: Read=1,MDRin,Mdatain=32'hA5A5 -> MDR=A5A5. Read=0,bus=7 ->
//     MDR=7. Zin with C=64'h1_0000_0002 -> ZHigh=1, ZLow=2. IRin with IR[18:0]=19'h40000
//     -> CSignExtended=32'hFFFC0000.
//   6 Conflict: Gra+Grb+Rin (ra=5, rb=6) -> only R5 loads, LoadConflict=1 and stays 1
//     until clear.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared datapath constants and helpers.
// Used by the bus destination bank and its select/encode logic.
package datapath_pkg;

  localparam int DW     = 32;
  localparam int NGPR   = 16;
  localparam int IDX_W  = 4;
  localparam int RA_MSB = 26;
  localparam int RB_MSB = 22;
  localparam int RC_MSB = 18;
  localparam int IMM_W  = 19;

  localparam logic [DW-1:0] RST_VAL = 32'h0;

  // Sign-extend the low IMM_W bits of an instruction word.
  function automatic logic [DW-1:0] sext_imm(
    input logic [DW-1:0] ir
  );
    return {{(DW-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
  endfunction

endpackage

// File: rtl/bus_dest_bank_select_encode.sv
// GPR select and one-hot encode from IR register fields.
// Purely combinational.
module select_encode
  import datapath_pkg::*;
(
  input  logic [DW-1:0]   ir,
  input  logic            gra,
  input  logic            grb,
  input  logic            grc,
  input  logic            rin,
  input  logic            rout,
  input  logic            baout,
  output logic [NGPR-1:0] gpr_load,
  output logic [NGPR-1:0] gpr_rout,
  output logic [NGPR-1:0] gpr_dec,
  output logic [DW-1:0]   c_sext,
  output logic            conflict
);

  logic [IDX_W-1:0] idx;
  logic             any_g;
  logic             multi_g;

  // Priority select of the register field: Gra > Grb > Grc.
  always_comb begin
    idx = '0;
    if (gra)
      idx = ir[RA_MSB -: IDX_W];
    else if (grb)
      idx = ir[RB_MSB -: IDX_W];
    else if (grc)
      idx = ir[RC_MSB -: IDX_W];
  end

  assign any_g   = gra | grb | grc;
  assign multi_g = (gra & grb) | (gra & grc) | (grb & grc);

  // One-hot decode; no field selected means no register.
  always_comb begin
    gpr_dec = '0;
    if (any_g)
      gpr_dec = NGPR'(1) << idx;
  end

  assign gpr_load = gpr_dec & {NGPR{rin}};
  assign gpr_rout = gpr_dec & {NGPR{rout | baout}};
  assign c_sext   = sext_imm(ir);
  assign conflict = multi_g & (rin | rout);

endmodule

// File: rtl/bus_dest_bank.sv
// Load side of the datapath bus: GPRs, HI/LO, PC, MDR, IR, Z.
// Returns all register contents and the GPR drive one-hot.
module bus_dest_bank
  import datapath_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  input  logic [DW-1:0]     BusMuxOut,
  input  logic              Gra,
  input  logic              Grb,
  input  logic              Grc,
  input  logic              Rin,
  input  logic              Rout,
  input  logic              BAout,
  input  logic              HIin,
  input  logic              LOin,
  input  logic              PCin,
  input  logic              IncPC,
  input  logic              MDRin,
  input  logic              Read,
  input  logic [DW-1:0]     Mdatain,
  input  logic              IRin,
  input  logic              Zin,
  input  logic [2*DW-1:0]   C,
  output logic [NGPR*DW-1:0] GprOut,
  output logic [DW-1:0]     HI,
  output logic [DW-1:0]     LO,
  output logic [DW-1:0]     PC,
  output logic [DW-1:0]     MDR,
  output logic [DW-1:0]     IR,
  output logic [DW-1:0]     ZHigh,
  output logic [DW-1:0]     ZLow,
  output logic [NGPR-1:0]   GprRout,
  output logic [DW-1:0]     CSignExtended,
  output logic              LoadConflict
);

  logic [NGPR-1:0] gpr_load;
  logic [NGPR-1:0] gpr_dec;
  logic            conflict;

  logic [DW-1:0]   hi_q,  hi_d;
  logic [DW-1:0]   lo_q,  lo_d;
  logic [DW-1:0]   pc_q,  pc_d;
  logic [DW-1:0]   mdr_q, mdr_d;
  logic [DW-1:0]   ir_q,  ir_d;
  logic [2*DW-1:0] z_q,   z_d;
  logic            lc_q,  lc_d;

  select_encode u_sel (
    .ir       (ir_q),
    .gra      (Gra),
    .grb      (Grb),
    .grc      (Grc),
    .rin      (Rin),
    .rout     (Rout),
    .baout    (BAout),
    .gpr_load (gpr_load),
    .gpr_rout (GprRout),
    .gpr_dec  (gpr_dec),
    .c_sext   (CSignExtended),
    .conflict (conflict)
  );

  // GPR bank: each register loads the bus on its one-hot strobe.
  for (genvar k = 0; k < NGPR; k++) begin : g_gpr
    logic [DW-1:0] r_q, r_d;

    // Next-state: hold unless selected for load.
    always_comb begin
      r_d = r_q;
      if (gpr_load[k])
        r_d = BusMuxOut;
    end

    // Register with synchronous clear.
    always_ff @(posedge clock) begin
      if (clear)
        r_q <= RST_VAL;
      else
        r_q <= r_d;
    end

    if (k == 0) begin : g_r0
      // R0 reads as zero on the bus during a base-address drive.
      assign GprOut[0 +: DW] =
        (BAout & gpr_dec[0]) ? '0 : r_q;
    end else begin : g_rk
      assign GprOut[k*DW +: DW] = r_q;
    end
  end

  // Next-state for the named special registers.
  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    pc_d  = pc_q;
    mdr_d = mdr_q;
    ir_d  = ir_q;
    z_d   = z_q;
    lc_d  = lc_q | conflict;
    if (HIin)
      hi_d = BusMuxOut;
    if (LOin)
      lo_d = BusMuxOut;
    if (PCin)
      pc_d = BusMuxOut;
    else if (IncPC)
      pc_d = pc_q + DW'(1);
    if (MDRin)
      mdr_d = Read ? Mdatain : BusMuxOut;
    if (IRin)
      ir_d = BusMuxOut;
    if (Zin)
      z_d = C;
  end

  // Special registers and the sticky conflict flag.
  always_ff @(posedge clock) begin
    if (clear) begin
      hi_q  <= RST_VAL;
      lo_q  <= RST_VAL;
      pc_q  <= RST_VAL;
      mdr_q <= RST_VAL;
      ir_q  <= RST_VAL;
      z_q   <= {RST_VAL, RST_VAL};
      lc_q  <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      pc_q  <= pc_d;
      mdr_q <= mdr_d;
      ir_q  <= ir_d;
      z_q   <= z_d;
      lc_q  <= lc_d;
    end
  end

  assign HI           = hi_q;
  assign LO           = lo_q;
  assign PC           = pc_q;
  assign MDR          = mdr_q;
  assign IR           = ir_q;
  assign ZHigh        = z_q[2*DW-1:DW];
  assign ZLow         = z_q[DW-1:0];
  assign LoadConflict = lc_q;

endmodule

// File: tb/tb_bus_dest_bank.sv
// Directed vector bench for bus_dest_bank.
// Each vector drives one cycle of strobes and checks one output.
module tb_bus_dest_bank;

  logic          clock = 0;
  logic          clear;
  logic [31:0]   BusMuxOut, Mdatain;
  logic          Gra, Grb, Grc, Rin, Rout, BAout;
  logic          HIin, LOin, PCin, IncPC;
  logic          MDRin, Read, IRin, Zin;
  logic [63:0]   C;
  logic [511:0]  GprOut;
  logic [31:0]   HI, LO, PC, MDR, IR;
  logic [31:0]   ZHigh, ZLow, CSignExtended;
  logic [15:0]   GprRout;
  logic          LoadConflict;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  bus_dest_bank dut (
    .clock(clock), .clear(clear),
    .BusMuxOut(BusMuxOut),
    .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .HIin(HIin), .LOin(LOin),
    .PCin(PCin), .IncPC(IncPC),
    .MDRin(MDRin), .Read(Read),
    .Mdatain(Mdatain),
    .IRin(IRin), .Zin(Zin), .C(C),
    .GprOut(GprOut),
    .HI(HI), .LO(LO), .PC(PC),
    .MDR(MDR), .IR(IR),
    .ZHigh(ZHigh), .ZLow(ZLow),
    .GprRout(GprRout),
    .CSignExtended(CSignExtended),
    .LoadConflict(LoadConflict)
  );

  localparam int B_GRA = 1 << 0;
  localparam int B_GRB = 1 << 1;
  localparam int B_GRC = 1 << 2;
  localparam int B_RIN = 1 << 3;
  localparam int B_ROUT = 1 << 4;
  localparam int B_BA  = 1 << 5;
  localparam int B_HI  = 1 << 6;
  localparam int B_LO  = 1 << 7;
  localparam int B_PC  = 1 << 8;
  localparam int B_INC = 1 << 9;
  localparam int B_MDR = 1 << 10;
  localparam int B_RD  = 1 << 11;
  localparam int B_IR  = 1 << 12;
  localparam int B_Z   = 1 << 13;
  localparam int B_CLR = 1 << 14;

  localparam int K_GPR  = 0;
  localparam int K_ROUT = 1;
  localparam int K_HI   = 2;
  localparam int K_LO   = 3;
  localparam int K_PC   = 4;
  localparam int K_MDR  = 5;
  localparam int K_IR   = 6;
  localparam int K_Z    = 7;
  localparam int K_SEXT = 8;
  localparam int K_LC   = 9;
  localparam int K_GALL = 10;

  typedef struct {
    string       name;
    int          ctl;
    logic [31:0] bus;
    logic [31:0] mdat;
    logic [63:0] c;
    int          kind;
    int          idx;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(
    input string nm, input int ctl,
    input logic [31:0] bus, input logic [31:0] mdat,
    input logic [63:0] c, input int kind,
    input int idx, input logic [63:0] exp
  );
    vec_t v;
    v.name = nm; v.ctl = ctl; v.bus = bus;
    v.mdat = mdat; v.c = c; v.kind = kind;
    v.idx = idx; v.exp = exp;
    vecs.push_back(v);
  endfunction

  function automatic logic [63:0] actual(
    input int kind, input int idx
  );
    case (kind)
      K_GPR:  return {32'h0, GprOut[idx*32 +: 32]};
      K_ROUT: return {48'h0, GprRout};
      K_HI:   return {32'h0, HI};
      K_LO:   return {32'h0, LO};
      K_PC:   return {32'h0, PC};
      K_MDR:  return {32'h0, MDR};
      K_IR:   return {32'h0, IR};
      K_Z:    return {ZHigh, ZLow};
      K_SEXT: return {32'h0, CSignExtended};
      K_LC:   return {63'h0, LoadConflict};
      K_GALL: return {63'h0, |GprOut};
      default: return 64'hDEAD;
    endcase
  endfunction

  task automatic drive(
    input int ctl, input logic [31:0] bus,
    input logic [31:0] mdat, input logic [63:0] c
  );
    Gra   = ctl[0];  Grb   = ctl[1];
    Grc   = ctl[2];  Rin   = ctl[3];
    Rout  = ctl[4];  BAout = ctl[5];
    HIin  = ctl[6];  LOin  = ctl[7];
    PCin  = ctl[8];  IncPC = ctl[9];
    MDRin = ctl[10]; Read  = ctl[11];
    IRin  = ctl[12]; Zin   = ctl[13];
    clear = ctl[14];
    BusMuxOut = bus; Mdatain = mdat; C = c;
  endtask

  task automatic check(
    input string nm, input logic [63:0] act,
    input logic [63:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step(
    input string nm, input int ctl,
    input logic [31:0] bus, input int kind,
    input int idx, input logic [63:0] exp
  );
    drive(ctl, bus, 32'h0, 64'h0);
    @(posedge clock); #1;
    check(nm, actual(kind, idx), exp);
  endtask

  initial begin
    add("ir_load", B_IR, 32'h0118_0000, 0, 0, K_IR, 0, 64'h0118_0000);
    add("r2_load", B_GRA|B_RIN, 32'hDEADBEEF, 0, 0, K_GPR, 2, 64'hDEADBEEF);
    add("rb_rout", B_GRB|B_ROUT, 0, 0, 0, K_ROUT, 0, 64'h0008);
    add("r3_load", B_GRB|B_RIN, 32'hCAFE, 0, 0, K_GPR, 3, 64'hCAFE);
    add("r2_hold", 0, 32'h1, 0, 0, K_GPR, 2, 64'hDEADBEEF);
    add("hi_load", B_HI, 32'h11, 0, 0, K_HI, 0, 64'h11);
    add("lo_load", B_LO, 32'h22, 0, 0, K_LO, 0, 64'h22);
    add("mdr_read", B_MDR|B_RD, 32'h9, 32'hA5A5, 0, K_MDR, 0, 64'hA5A5);
    add("mdr_bus", B_MDR, 32'h7, 32'hA5A5, 0, K_MDR, 0, 64'h7);
    add("mdr_hold", B_RD, 32'h8, 32'h3, 0, K_MDR, 0, 64'h7);
    add("z_load", B_Z, 0, 0, 64'h1_0000_0002, K_Z, 0, 64'h1_0000_0002);
    add("pc_load", B_PC, 32'hFFFFFFFF, 0, 0, K_PC, 0, 64'hFFFFFFFF);
    add("pc_wrap", B_INC, 0, 0, 0, K_PC, 0, 64'h0);
    add("pc_prio", B_PC|B_INC, 32'h10, 0, 0, K_PC, 0, 64'h10);
    add("pc_inc", B_INC, 0, 0, 0, K_PC, 0, 64'h11);
    add("sext_neg", B_IR, 32'h0004_0000, 0, 0, K_SEXT, 0, 64'hFFFC0000);
    add("r0_load", B_GRA|B_RIN, 32'h1234, 0, 0, K_GPR, 0, 64'h1234);
    add("r0_ba", B_GRA|B_BA, 0, 0, 0, K_GPR, 0, 64'h0);
    add("r0_ba_rout", B_GRA|B_BA, 0, 0, 0, K_ROUT, 0, 64'h0001);
    add("r0_rout", B_GRA|B_ROUT, 0, 0, 0, K_GPR, 0, 64'h1234);
    add("rin_nog", B_RIN, 32'h999, 0, 0, K_GPR, 0, 64'h1234);
    add("rout_nog", B_ROUT, 0, 0, 0, K_ROUT, 0, 64'h0);
    add("sext_pos", B_IR, 32'h0003_FFFF, 0, 0, K_SEXT, 0, 64'h0003FFFF);
    add("r7_grc", B_GRC|B_RIN, 32'h77, 0, 0, K_GPR, 7, 64'h77);
    add("lc_clean", 0, 0, 0, 0, K_LC, 0, 64'h0);

    drive(B_CLR, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    check("rst_gpr", actual(K_GALL, 0), 64'h0);
    check("rst_pc", actual(K_PC, 0), 64'h0);
    check("rst_lc", actual(K_LC, 0), 64'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].ctl, vecs[i].bus,
            vecs[i].mdat, vecs[i].c);
      @(posedge clock); #1;
      check(vecs[i].name,
            actual(vecs[i].kind, vecs[i].idx),
            vecs[i].exp);
    end

    // Conflict: ra=5, rb=6; only R5 loads, flag is sticky.
    step("cf_ir", B_IR, 32'h02B0_0000, K_IR, 0, 64'h02B0_0000);
    step("cf_r5", B_GRA|B_GRB|B_RIN, 32'h55, K_GPR, 5, 64'h55);
    check("cf_r6", actual(K_GPR, 6), 64'h0);
    check("cf_set", actual(K_LC, 0), 64'h1);
    step("cf_hold1", 0, 0, K_LC, 0, 64'h1);
    step("cf_hold2", B_GRA|B_RIN, 32'h66, K_LC, 0, 64'h1);

    // Clear wins over simultaneous strobes.
    step("clr_gpr", B_CLR|B_GRA|B_RIN|B_PC, 32'hFFFF, K_GALL, 0, 64'h0);
    check("clr_pc", actual(K_PC, 0), 64'h0);
    check("clr_lc", actual(K_LC, 0), 64'h0);
    check("clr_hi", actual(K_HI, 0), 64'h0);
    check("clr_mdr", actual(K_MDR, 0), 64'h0);
    check("clr_ir", actual(K_IR, 0), 64'h0);
    check("clr_z", actual(K_Z, 0), 64'h0);

    drive(0, 0, 0, 0);
    @(posedge clock); #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
